// File: rtl/token_sched_pkg.sv
// Purpose: shared defaults and types for the token ratio scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package token_sched_pkg;

    // Default geometry: four channels, 3-bit ratios, 3-bit pending counters.
    localparam int N_CH      = 4;
    localparam int DIV_W     = 3;
    localparam int PEND_W    = 3;

    // Reset ratio reproduces the original fixed halving stage.
    localparam int DIV_RESET = 2;

    typedef logic [$clog2(N_CH)-1:0] chan_id_t;
    typedef logic [DIV_W-1:0]        div_t;
    typedef logic [PEND_W-1:0]       pend_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter; one-hot grant plus encoded id, owns last_grant.
// Latency: combinational grant; last_grant updates on the edge of a grant.
// Backpressure: en low suppresses the grant and freezes the round-robin pointer.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   req        per-channel request vector
//   en         grant enable (downstream slot available)
//   grant      one-hot grant, all zero when en=0 or no request
//   grant_id   encoded index of the granted channel
module rr_arbiter
    import token_sched_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] last_grant;
    logic            any_req;

    assign any_req = |req;

    // Scan starting one past the previous winner and wrap at N-1, so the
    // most recently served channel is always looked at last.
    always_comb begin
        logic            found;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        grant    = '0;
        grant_id = '0;
        for (int off = 1; off <= N; off++) begin
            // One extra bit keeps last_grant + off from wrapping before the
            // explicit modulo-N correction; this also covers non-power-of-two N.
            sum = {1'b0, last_grant} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = idx;
                grant    = '0;
                grant[idx] = en;
            end
        end
    end

    // Pointer starts at N-1 so channel 0 has first priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= ID_W'(N - 1);
        end else if (en && any_req) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/token_ratio_scheduler.sv
// Purpose: per-channel token ratio dividers sharing one output channel via round-robin.
// Latency: completion registered into pending at edge k, out_valid after edge k+1.
// Backpressure: out_valid/out_id held while out_ready=0; completions queue in pending, overflow drops and sets ovf.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   a[N_CH]                      one token per channel per cycle when high
//   cfg_valid/cfg_id/cfg_div     ratio write; clears phase and ovf of cfg_id
//   out_valid/out_id/out_ready   one-entry valid/ready output stage
//   ovf[N_CH]                    sticky per-channel pending-overflow flags
module token_ratio_scheduler #(
    parameter  int N_CH   = token_sched_pkg::N_CH,
    parameter  int DIV_W  = token_sched_pkg::DIV_W,
    parameter  int PEND_W = token_sched_pkg::PEND_W,
    localparam int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   a,
    input  logic              cfg_valid,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    input  logic              out_ready,
    output logic [N_CH-1:0]   ovf
);

    import token_sched_pkg::*;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic            stage_free;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant;
    logic [ID_W-1:0] grant_id;

    // The output register can accept a new token when empty or when the
    // token it holds is being consumed this cycle.
    assign stage_free = !out_valid || out_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0]  div_q;
        logic [DIV_W-1:0]  phase_q;
        logic [PEND_W-1:0] pend_q;
        logic              ovf_q;
        logic              cfg_hit;
        logic              tok;
        logic              done;

        assign cfg_hit = cfg_valid && (cfg_id == ID_W'(i));

        // A token arriving with its own channel's config write is discarded,
        // so the new ratio always starts counting from a clean phase.
        assign tok  = a[i] && (div_q != '0) && !cfg_hit;
        assign done = tok && (phase_q == div_q - DIV_W'(1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                div_q   <= DIV_W'(DIV_RESET);
                phase_q <= '0;
            end else if (cfg_hit) begin
                div_q   <= cfg_div;
                phase_q <= '0;
            end else if (tok) begin
                phase_q <= done ? '0 : phase_q + DIV_W'(1);
            end
        end

        // Pending is preserved across config writes. A completion and a grant
        // in the same cycle cancel, even at saturation, so no drop occurs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pend_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                unique case ({done, grant[i]})
                    2'b10: begin
                        if (pend_q != PEND_MAX) begin
                            pend_q <= pend_q + PEND_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    2'b01:   pend_q <= pend_q - PEND_W'(1);
                    default: pend_q <= pend_q;
                endcase
                if (cfg_hit) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        // The arbiter sees only registered pending counts; a completion in the
        // current cycle becomes eligible on the next one.
        assign req[i] = (pend_q != '0);
        assign ovf[i] = ovf_q;
    end

    rr_arbiter #(
        .N        (N_CH)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .en       (stage_free),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_id    <= '0;
        end else if (stage_free) begin
            out_valid <= |grant;
            if (|grant) begin
                out_id <= grant_id;
            end
        end
    end

endmodule
